// File: rtl/sram_mc_pkg.sv
// sram_mc_pkg: shared types and sizing helpers for the multi-channel SRAM controller.
package sram_mc_pkg;

  localparam int BEAT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_STB,
    WR_SETUP,
    WR_STB,
    WR_HOLD,
    RESP
  } state_e;

  // Number of 16-bit beats needed for one host word.
  function automatic int calc_beats(input int data_w);
    return data_w / BEAT_W;
  endfunction

  // Beat counter width; at least one bit so single-beat builds still elaborate.
  function automatic int calc_beat_cnt_w(input int data_w);
    int b;
    b = data_w / BEAT_W;
    return (b > 1) ? $clog2(b) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; the search starts one past the last
// accepted requester, and the pointer resets to requester 0.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;
  logic [IW:0]   cand;
  logic          found;

  // First requester at or after the pointer, wrapping past N-1 back to 0.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req[cand[IW-1:0]]) begin
        found                 = 1'b1;
        grant[cand[IW-1:0]]   = 1'b1;
        grant_idx             = cand[IW-1:0];
      end
    end
  end

  // Advance the pointer past the winner only when the grant is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ptr <= '0;
    else if (accept) ptr <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/sram_mc_ctrl.sv
// sram_mc_ctrl: round-robin multi-channel controller for the 16-bit async SRAM.
// Each host word is split into 16-bit beats with WAIT_CYCLES extra strobe cycles.
// Define SRAM_MC_CTRL_STATS_EN to add the stat_xfers / stat_busy_cycles counters.
module sram_mc_ctrl
  import sram_mc_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          req_valid,
  output logic [CHANNELS-1:0]          req_ready,
  input  logic [CHANNELS-1:0]          req_write,
  input  logic [CHANNELS*ADDR_W-1:0]   req_addr,
  input  logic [CHANNELS*DATA_W-1:0]   req_wdata,
  input  logic [CHANNELS*DATA_W/8-1:0] req_be,
  output logic [CHANNELS-1:0]          rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         busy,
  output logic [ADDR_W-1:0]            sram_addr,
  output logic [15:0]                  sram_dq_o,
  output logic                         sram_dq_oe,
  input  logic [15:0]                  sram_dq_i,
  output logic                         sram_ce_n,
  output logic                         sram_oe_n,
  output logic                         sram_we_n,
  output logic                         sram_ub_n,
  output logic                         sram_lb_n
`ifdef SRAM_MC_CTRL_STATS_EN
  ,
  output logic [31:0]                  stat_xfers,
  output logic [31:0]                  stat_busy_cycles
`endif
);

  localparam int BEATS = calc_beats(DATA_W);
  localparam int CNT_W = calc_beat_cnt_w(DATA_W);
  localparam int BE_W  = DATA_W / 8;
  localparam int GW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic [2:0]          wcnt_q, wcnt_d;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q, n_addr, addr_nx;
  logic [DATA_W-1:0]   wdata_q, rdata_q, n_wdata;
  logic [BE_W-1:0]     be_q, n_be;
  logic [CHANNELS-1:0] gnt_q, grant;
  logic [GW-1:0]       gidx;
  logic                accept, last_wait, last_beat;
  logic                active_d, wr_d;
  logic [1:0]          beat_be;
  logic [15:0]         dq_nx;
  logic                ce_nx, oe_nx, we_nx, ub_nx, lb_nx;

  rr_arbiter #(.N(CHANNELS)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign accept    = (state_q == IDLE) && (|req_valid) && !reset;
  assign req_ready = (state_q == IDLE && !reset) ? grant : '0;
  assign last_wait = (wcnt_q == 3'(WAIT_CYCLES));
  assign last_beat = (beat_q == CNT_W'(BEATS-1));

  // The accept cycle already programs the first beat's pins, so source the
  // request directly from the winning channel instead of the latched copy.
  assign n_addr  = accept ? req_addr[int'(gidx)*ADDR_W +: ADDR_W]   : addr_q;
  assign n_wdata = accept ? req_wdata[int'(gidx)*DATA_W +: DATA_W] : wdata_q;
  assign n_be    = accept ? req_be[int'(gidx)*BE_W +: BE_W]        : be_q;

  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP) ? gnt_q : '0;
  assign rsp_rdata = (state_q == RESP && !wr_q) ? rdata_q : '0;

  // FSM state register plus beat and wait-state counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next state and the pin values that state implies (pins are registered below).
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = req_write[gidx] ? WR_SETUP : RD_STB;
        beat_d  = '0;
        wcnt_d  = '0;
      end
      RD_STB: if (last_wait) begin
        wcnt_d = '0;
        if (last_beat) state_d = RESP;
        else           beat_d  = beat_q + 1'b1;
      end else wcnt_d = wcnt_q + 1'b1;
      WR_SETUP: begin
        state_d = WR_STB;
        wcnt_d  = '0;
      end
      WR_STB: if (last_wait) state_d = WR_HOLD;
              else           wcnt_d  = wcnt_q + 1'b1;
      WR_HOLD: if (last_beat) state_d = RESP;
      else begin
        state_d = WR_SETUP;
        beat_d  = beat_q + 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    wr_d     = (state_d == WR_SETUP) || (state_d == WR_STB) || (state_d == WR_HOLD);
    active_d = wr_d || (state_d == RD_STB);
    beat_be  = n_be[int'(beat_d)*2 +: 2];
    ce_nx    = !active_d;
    oe_nx    = (state_d != RD_STB);
    // A beat with no byte enabled still runs its cycles, just without a strobe.
    we_nx    = !((state_d == WR_STB) && (|beat_be));
    ub_nx    = wr_d ? !beat_be[1] : !active_d;
    lb_nx    = wr_d ? !beat_be[0] : !active_d;
    dq_nx    = wr_d ? n_wdata[int'(beat_d)*BEAT_W +: BEAT_W] : '0;
    addr_nx  = active_d ? n_addr + ADDR_W'(beat_d) : sram_addr;
  end

  // Registered SRAM pins; reset forces them idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
    end else begin
      sram_addr  <= addr_nx;
      sram_dq_o  <= dq_nx;
      sram_dq_oe <= wr_d;
      sram_ce_n  <= ce_nx;
      sram_oe_n  <= oe_nx;
      sram_we_n  <= we_nx;
      sram_ub_n  <= ub_nx;
      sram_lb_n  <= lb_nx;
    end
  end

  // Latch the accepted request and assemble read beats little-endian.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      gnt_q   <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      wr_q    <= req_write[gidx];
      addr_q  <= n_addr;
      wdata_q <= n_wdata;
      be_q    <= n_be;
      gnt_q   <= grant;
      rdata_q <= '0;
    end else if (state_q == RD_STB && last_wait) begin
      rdata_q[int'(beat_q)*BEAT_W +: BEAT_W] <= sram_dq_i;
    end
  end

`ifdef SRAM_MC_CTRL_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_xfers       <= '0;
      stat_busy_cycles <= '0;
    end else begin
      if (state_q == RESP && stat_xfers != '1) stat_xfers <= stat_xfers + 32'd1;
      if (busy && stat_busy_cycles != '1)      stat_busy_cycles <= stat_busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_mc_ctrl.sv
// tb_sram_mc_ctrl: randomized and directed checks of sram_mc_ctrl against an
// SRAM pin model and a transaction-level shadow memory.
`timescale 1ns/1ps
module tb_sram_mc_ctrl;

  localparam int CH    = 2;
  localparam int AW    = 20;
  localparam int DW    = 32;
  localparam int WC    = 1;
  localparam int BEATS = DW / 16;
  localparam int BW    = DW / 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [CH-1:0]     req_valid = '0, req_write = '0, req_ready, rsp_valid;
  logic [CH*AW-1:0]  req_addr = '0;
  logic [CH*DW-1:0]  req_wdata = '0;
  logic [CH*BW-1:0]  req_be = '0;
  logic [DW-1:0]     rsp_rdata;
  logic              busy;
  logic [AW-1:0]     sram_addr;
  logic [15:0]       sram_dq_o;
  logic [15:0]       sram_dq_i = '0;
  logic              sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
`ifdef SRAM_MC_CTRL_STATS_EN
  logic [31:0]       stat_xfers, stat_busy_cycles;
`endif

  int n_tests = 0, n_fail = 0;
  int cyc = 0, we_low = 0, viol = 0, rsp_pulses = 0, rr_next = 0;
  logic [15:0] sram   [logic [AW-1:0]];
  logic [15:0] shadow [logic [AW-1:0]];
  logic [15:0] mon_w;

  sram_mc_ctrl #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
`ifdef SRAM_MC_CTRL_STATS_EN
    , .stat_xfers(stat_xfers), .stat_busy_cycles(stat_busy_cycles)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] rd_sram(input logic [AW-1:0] a);
    return sram.exists(a) ? sram[a] : 16'h0;
  endfunction

  function automatic logic [15:0] rd_sh(input logic [AW-1:0] a);
    return shadow.exists(a) ? shadow[a] : 16'h0;
  endfunction

  // Asynchronous SRAM pin model, evaluated mid-cycle while pins are stable.
  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      mon_w = rd_sram(sram_addr);
      if (!sram_ub_n) mon_w[15:8] = sram_dq_o[15:8];
      if (!sram_lb_n) mon_w[7:0]  = sram_dq_o[7:0];
      sram[sram_addr] = mon_w;
      we_low++;
      if (!sram_dq_oe) viol++;
    end
    if (!sram_oe_n && sram_dq_oe) viol++;
    if (rsp_valid != '0) rsp_pulses++;
    sram_dq_i = (!sram_ce_n && !sram_oe_n) ? rd_sram(sram_addr) : 16'h0;
  end

  // One transaction on one channel, checked against the shadow memory model.
  task automatic run_txn(input int ch, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [BW-1:0] be, input string nm);
    int t_acc, exp_lat, exp_we, we0;
    bit got;
    logic [DW-1:0] exp_rd;
    logic [AW-1:0] ab;
    logic [15:0] w;
    logic [1:0] bb;
    exp_rd = '0;
    exp_we = 0;
    t_acc  = 0;
    for (int b = 0; b < BEATS; b++) begin
      ab = a + AW'(b);
      exp_rd[b*16 +: 16] = rd_sh(ab);
    end
    exp_lat = 1 + BEATS * (wr ? WC + 3 : WC + 1);
    we0 = we_low;
    @(posedge clk); #1;
    req_valid[ch] = 1'b1;
    req_write[ch] = wr;
    req_addr[ch*AW +: AW]  = a;
    req_wdata[ch*DW +: DW] = wd;
    req_be[ch*BW +: BW]    = be;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (req_ready[ch]) begin got = 1; t_acc = cyc; end
    end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL %s accept: req_ready=%b never granted ch%0d", nm, req_ready, ch); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_accept: got %b want 0", nm, busy); end
    @(posedge clk); #1;
    req_valid[ch] = 1'b0;
    rr_next = (ch + 1) % CH;
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) got = 1;
    end
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL %s rsp_timeout: no rsp_valid", nm);
    end else begin
      n_tests++;
      if (rsp_valid !== CH'(1 << ch)) begin n_fail++; $display("FAIL %s rsp_valid: got %b want %b", nm, rsp_valid, CH'(1 << ch)); end
      n_tests++;
      if (cyc - t_acc != exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", nm, cyc - t_acc, exp_lat); end
      n_tests++;
      if (rsp_rdata !== (wr ? {DW{1'b0}} : exp_rd)) begin n_fail++; $display("FAIL %s rdata: got %h want %h", nm, rsp_rdata, wr ? {DW{1'b0}} : exp_rd); end
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_in_resp: got %b want 1", nm, busy); end
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || rsp_valid !== '0) begin n_fail++; $display("FAIL %s after_resp: busy=%b rsp_valid=%b want 0/0", nm, busy, rsp_valid); end
    if (wr) begin
      for (int b = 0; b < BEATS; b++) begin
        ab = a + AW'(b);
        w  = rd_sh(ab);
        bb = be[b*2 +: 2];
        if (bb[0]) w[7:0]  = wd[b*16 +: 8];
        if (bb[1]) w[15:8] = wd[b*16+8 +: 8];
        shadow[ab] = w;
        if (bb != 2'b00) exp_we += WC + 1;
        n_tests++;
        if (rd_sram(ab) !== w) begin n_fail++; $display("FAIL %s mem[%h]: got %h want %h", nm, ab, rd_sram(ab), w); end
      end
      n_tests++;
      if (we_low - we0 != exp_we) begin n_fail++; $display("FAIL %s we_cycles: got %0d want %0d", nm, we_low - we0, exp_we); end
    end
    n_tests++;
    if (viol != 0) begin n_fail++; $display("FAIL %s pin_protocol: %0d violations want 0", nm, viol); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (req_ready !== '0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    n_tests++;
    if (busy !== 1'b0 || rsp_valid !== '0 || rsp_rdata !== '0) begin
      n_fail++; $display("FAIL rst_outputs: busy=%b rsp_valid=%b rdata=%h want 0", busy, rsp_valid, rsp_rdata);
    end
    n_tests++;
    if (sram_addr !== '0 || sram_dq_o !== '0 || sram_dq_oe !== 1'b0) begin
      n_fail++; $display("FAIL rst_bus: addr=%h dq_o=%h oe=%b want 0", sram_addr, sram_dq_o, sram_dq_oe);
    end
    n_tests++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
      n_fail++; $display("FAIL rst_strobes: got %b want 11111", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
    end
    req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    rr_next = 0;
  endtask

  task automatic test_single_read();
    sram[20'h00010] = 16'h1234; shadow[20'h00010] = 16'h1234;
    sram[20'h00011] = 16'hABCD; shadow[20'h00011] = 16'hABCD;
    run_txn(0, 1'b0, 20'h00010, '0, '0, "single_read");
  endtask

  task automatic test_single_write();
    run_txn(1, 1'b1, 20'hFFFFF, 32'hCAFEBEEF, 4'b1111, "single_write");
    n_tests++;
    if (rd_sram(20'hFFFFF) !== 16'hBEEF || rd_sram(20'h00000) !== 16'hCAFE) begin
      n_fail++; $display("FAIL wrap_write: got %h/%h want BEEF/CAFE", rd_sram(20'hFFFFF), rd_sram(20'h00000));
    end
  endtask

  task automatic test_partial_write();
    sram[20'h00200] = 16'h1111; shadow[20'h00200] = 16'h1111;
    sram[20'h00201] = 16'h2222; shadow[20'h00201] = 16'h2222;
    run_txn(0, 1'b1, 20'h00200, 32'h55667788, 4'b0010, "partial_write");
    n_tests++;
    if (rd_sram(20'h00200) !== 16'h7711 || rd_sram(20'h00201) !== 16'h2222) begin
      n_fail++; $display("FAIL partial_bytes: got %h/%h want 7711/2222", rd_sram(20'h00200), rd_sram(20'h00201));
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : 20'hFFFF0 + AW'($urandom_range(0, 15));
      run_txn($urandom_range(0, CH - 1), 1'($urandom_range(0, 1)), a, DW'($urandom),
              BW'($urandom_range(0, 15)), "random");
    end
  endtask

  task automatic test_back_to_back();
    int t_prev, exp_g;
    bit got;
    logic [CH-1:0] g;
    t_prev = -1;
    g = '0;
    @(posedge clk); #1;
    req_write = '0;
    req_addr  = {20'h00050, 20'h00040};
    req_valid = '1;
    for (int n = 0; n < 4; n++) begin
      got = 0;
      for (int k = 0; k < 100 && !got; k++) begin
        @(negedge clk);
        if (req_ready != '0) begin got = 1; g = req_ready; end
      end
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL b2b_accept%0d: no grant", n); end
      exp_g = rr_next;
      n_tests++;
      if (g !== CH'(1 << exp_g)) begin n_fail++; $display("FAIL b2b_grant%0d: got %b want %b", n, g, CH'(1 << exp_g)); end
      if (t_prev >= 0) begin
        n_tests++;
        if (cyc - t_prev != 2 + BEATS * (WC + 1)) begin
          n_fail++; $display("FAIL b2b_gap%0d: got %0d want %0d", n, cyc - t_prev, 2 + BEATS * (WC + 1));
        end
      end
      t_prev  = cyc;
      rr_next = (exp_g + 1) % CH;
      @(posedge clk);
    end
    #1 req_valid = '0;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin @(negedge clk); if (!busy) got = 1; end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL b2b_drain: busy stuck at 1"); end
  endtask

  task automatic test_reset_mid();
    bit got;
    int p0;
    @(posedge clk); #1;
    req_write[0] = 1'b1;
    req_addr[0 +: AW]  = 20'h00300;
    req_wdata[0 +: DW] = 32'h0BAD_F00D;
    req_be[0 +: BW]    = 4'b1111;
    req_valid = 2'b01;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin @(negedge clk); if (req_ready[0]) got = 1; end
    @(posedge clk); #1;
    req_valid = '0;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin @(negedge clk); if (!sram_we_n) got = 1; end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL rstmid_strobe: we_n never fell"); end
    p0 = rsp_pulses;
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 6'b111110) begin
      n_fail++; $display("FAIL rstmid_pins: got %b want 111110", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe});
    end
    n_tests++;
    if (busy !== 1'b0 || rsp_valid !== '0) begin n_fail++; $display("FAIL rstmid_busy: busy=%b rsp_valid=%b want 0", busy, rsp_valid); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rr_next = 0;
    req_write = '0;
    req_addr  = {20'h00060, 20'h00070};
    req_valid = '1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== CH'(1 << rr_next)) begin n_fail++; $display("FAIL rstmid_grant: got %b want %b", req_ready, CH'(1 << rr_next)); end
    @(posedge clk); #1;
    req_valid = '0;
    rr_next = 1;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin @(negedge clk); if (!busy) got = 1; end
    n_tests++;
    if (rsp_pulses - p0 != 1) begin n_fail++; $display("FAIL rstmid_rsp: got %0d pulses want 1", rsp_pulses - p0); end
    shadow[20'h00300] = rd_sram(20'h00300);
    shadow[20'h00301] = rd_sram(20'h00301);
  endtask

`ifdef SRAM_MC_CTRL_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rr_next = 0;
    for (int i = 0; i < 3; i++) run_txn(i % CH, 1'b0, AW'(i * 4), '0, '0, "stats_read");
    n_tests++;
    if (stat_xfers !== 32'd3) begin n_fail++; $display("FAIL stat_xfers: got %0d want 3", stat_xfers); end
    n_tests++;
    if (stat_busy_cycles !== 32'(3 * (BEATS * (WC + 1) + 1))) begin
      n_fail++; $display("FAIL stat_busy: got %0d want %0d", stat_busy_cycles, 3 * (BEATS * (WC + 1) + 1));
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_partial_write();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef SRAM_MC_CTRL_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
